uart_tx: RTL and testbench

Serial UART transmitter producing 8N1 frames (1 start bit, 8 data bits LSB first, no parity, 1 stop bit) on a single TX line. It converts a byte written with a one-cycle `Start` strobe into a serial frame. It signals completion on `EOT`. It sits between the controller's parallel data path and the board-level serial output; bit timing is derived from the system clock by integer division.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_gen.sv | 29 ++
 rtl/uart_tx.sv | 96 +++++++++
 tb/tb_uart_tx.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART blocks.
// Holds the transmitter state encoding and the clock-to-baud divisor calculation.
package uart_pkg;

   localparam int unsigned UART_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

   // Whole clock cycles per serial bit; any fractional remainder is dropped.
   function automatic int unsigned bit_cycles(input int unsigned freq, input int unsigned speed);
      return freq / speed;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running bit-period divider with synchronous clear.
// Emits a one-cycle tick on the last cycle of each DIV-cycle period.
module uart_baud_gen #(
   parameter int unsigned DIV = 868
) (
   input  logic Clk,
   input  logic Rst_n,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         cnt_reg <= '0;
      end else if (clr || tick) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   assign tick = (cnt_reg == CNT_MAX);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one Start strobe in IDLE launches a start bit, eight data
// bits LSB first and a stop bit; EOT is high only while idle.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned FREQ_CLK = 100000000,
   parameter int unsigned TX_SPEED = 115200
) (
   input  logic                   Clk,
   input  logic                   Rst_n,
   input  logic [UART_DATA_W-1:0] Data,
   input  logic                   Start,
   output logic                   EOT,
   output logic                   TX
);

   localparam int unsigned BIT_CYC = bit_cycles(FREQ_CLK, TX_SPEED);
   localparam logic [2:0]  LAST_BIT = 3'(UART_DATA_W - 1);

   tx_state_t              state_reg;
   logic [UART_DATA_W-1:0] shift_reg;
   logic [2:0]             bit_idx_reg;
   logic                   tx_reg;
   logic                   eot_reg;
   logic                   bit_tick;
   logic                   baud_clr;

   // Holding the divider in clear while idle aligns the first tick to the acceptance edge.
   assign baud_clr = (state_reg == IDLE);

   uart_baud_gen #(
      .DIV (BIT_CYC)
   ) u_baud (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .clr   (baud_clr),
      .tick  (bit_tick)
   );

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_reg   <= IDLE;
         shift_reg   <= '0;
         bit_idx_reg <= '0;
         tx_reg      <= 1'b1;
         eot_reg     <= 1'b1;
      end else begin
         case (state_reg)
            IDLE: begin
               if (Start) begin
                  state_reg <= START;
                  shift_reg <= Data;
                  tx_reg    <= 1'b0;
                  eot_reg   <= 1'b0;
               end
            end
            START: begin
               if (bit_tick) begin
                  state_reg   <= DATA;
                  bit_idx_reg <= '0;
                  tx_reg      <= shift_reg[0];
               end
            end
            DATA: begin
               if (bit_tick) begin
                  if (bit_idx_reg == LAST_BIT) begin
                     state_reg   <= STOP;
                     bit_idx_reg <= '0;
                     tx_reg      <= 1'b1;
                  end else begin
                     // Next level is taken from bit 1 so TX stays registered with no extra stage.
                     shift_reg   <= shift_reg >> 1;
                     bit_idx_reg <= bit_idx_reg + 3'd1;
                     tx_reg      <= shift_reg[1];
                  end
               end
            end
            STOP: begin
               if (bit_tick) begin
                  state_reg <= IDLE;
                  eot_reg   <= 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
               tx_reg    <= 1'b1;
               eot_reg   <= 1'b1;
            end
         endcase
      end
   end

   assign TX  = tx_reg;
   assign EOT = eot_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 115200 baud plus a 9600-baud instance for bit timing.
module tb_uart_tx;

   localparam int BIT       = 868;
   localparam int FRAME     = 10 * BIT;
   localparam int SLOW_BIT  = 10416;

   logic       Clk    = 1'b0;
   logic       Rst_n  = 1'b0;
   logic       Start  = 1'b0;
   logic       Start2 = 1'b0;
   logic [7:0] Data   = 8'h00;
   logic [7:0] Data2  = 8'h00;
   logic       EOT, TX, EOT2, TX2;

   int checks = 0;
   int passed = 0;

   always #5 Clk = ~Clk;

   uart_tx dut (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .Data  (Data),
      .Start (Start),
      .EOT   (EOT),
      .TX    (TX)
   );

   uart_tx #(
      .FREQ_CLK (100000000),
      .TX_SPEED (9600)
   ) dut_slow (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .Data  (Data2),
      .Start (Start2),
      .EOT   (EOT2),
      .TX    (TX2)
   );

   // Pulse Start for one edge, then scramble Data to show it is no longer looked at.
   task automatic kick(input logic [7:0] d);
      @(negedge Clk);
      Data  = d;
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      Data  = ~d;
   endtask

   // Records one frame slot by slot, starting at the negedge right after the accepting edge.
   task automatic capture_frame(input int inject_cyc, output logic [9:0] bits,
                                output bit stable, output int eot_low);
      stable  = 1'b1;
      eot_low = 0;
      bits    = '0;
      for (int c = 0; c < FRAME; c++) begin
         if (c % BIT == 0) bits[c / BIT] = TX;
         else if (TX !== bits[c / BIT]) stable = 1'b0;
         if (EOT === 1'b0) eot_low++;
         if (c == inject_cyc) begin
            Start = 1'b1;
            Data  = 8'h55;
         end else if (c == inject_cyc + 1) begin
            Start = 1'b0;
         end
         @(negedge Clk);
      end
   endtask

   task automatic test_reset();
      int bad;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge Clk);
         if (TX !== 1'b1 || EOT !== 1'b1) bad++;
      end
      checks++;
      if (bad !== 0) $display("FAIL reset_hold: %0d cycles with TX/EOT not 1, required 0", bad);
      else passed++;
      Rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge Clk);
         if (TX !== 1'b1 || EOT !== 1'b1) bad++;
      end
      checks++;
      if (bad !== 0) $display("FAIL reset_release: %0d cycles with TX/EOT not 1, required 0", bad);
      else passed++;
      $display("reset: hold and release observed");
   endtask

   task automatic test_single();
      logic [9:0] bits;
      bit         stable;
      int         eot_low;
      kick(8'hAA);
      capture_frame(-1, bits, stable, eot_low);
      checks++;
      if (bits !== 10'b1101010100) $display("FAIL aa_bits: got %b required %b", bits, 10'b1101010100);
      else passed++;
      checks++;
      if (stable !== 1'b1) $display("FAIL aa_bit_width: TX changed inside a %0d-cycle bit", BIT);
      else passed++;
      checks++;
      if (eot_low !== FRAME) $display("FAIL aa_eot_low: got %0d required %0d", eot_low, FRAME);
      else passed++;
      checks++;
      if (EOT !== 1'b1 || TX !== 1'b1) $display("FAIL aa_end: EOT=%b TX=%b required 1 1", EOT, TX);
      else passed++;
      $display("frame 0xAA: bits=%b eot_low=%0d", bits, eot_low);
   endtask

   task automatic test_two_frames();
      logic [9:0] bits;
      bit         stable;
      int         eot_low;
      int         idle_bad;
      kick(8'h03);
      capture_frame(-1, bits, stable, eot_low);
      checks++;
      if (bits !== 10'b1000000110 || stable !== 1'b1)
         $display("FAIL x03_bits: got %b stable=%b required %b stable=1", bits, stable, 10'b1000000110);
      else passed++;
      checks++;
      if (eot_low !== FRAME) $display("FAIL x03_eot_low: got %0d required %0d", eot_low, FRAME);
      else passed++;
      $display("frame 0x03: bits=%b eot_low=%0d", bits, eot_low);
      idle_bad = 0;
      for (int i = 0; i < 3000; i++) begin
         if (EOT !== 1'b1 || TX !== 1'b1) idle_bad++;
         @(negedge Clk);
      end
      checks++;
      if (idle_bad !== 0) $display("FAIL gap_idle: %0d non-idle cycles, required 0", idle_bad);
      else passed++;
      kick(8'hCC);
      capture_frame(-1, bits, stable, eot_low);
      checks++;
      if (bits !== 10'b1110011000 || stable !== 1'b1)
         $display("FAIL xcc_bits: got %b stable=%b required %b stable=1", bits, stable, 10'b1110011000);
      else passed++;
      checks++;
      if (eot_low !== FRAME || EOT !== 1'b1)
         $display("FAIL xcc_eot: low=%0d end=%b required %0d and 1", eot_low, EOT, FRAME);
      else passed++;
      $display("frame 0xCC: bits=%b eot_low=%0d", bits, eot_low);
   endtask

   task automatic test_ignore_start();
      logic [9:0] bits;
      bit         stable;
      int         eot_low;
      int         extra;
      kick(8'hAA);
      capture_frame(4000, bits, stable, eot_low);
      checks++;
      if (bits !== 10'b1101010100 || stable !== 1'b1)
         $display("FAIL busy_start_frame: got %b stable=%b required %b stable=1", bits, stable, 10'b1101010100);
      else passed++;
      checks++;
      if (eot_low !== FRAME) $display("FAIL busy_start_eot: got %0d required %0d", eot_low, FRAME);
      else passed++;
      extra = 0;
      for (int i = 0; i < 2 * BIT; i++) begin
         if (EOT !== 1'b1 || TX !== 1'b1) extra++;
         @(negedge Clk);
      end
      checks++;
      if (extra !== 0) $display("FAIL busy_start_no_second: %0d non-idle cycles, required 0", extra);
      else passed++;
      $display("busy Start 0x55 mid-frame: bits=%b extra=%0d", bits, extra);
   endtask

   // Ends on the negedge where EOT has just risen, which the back-to-back test relies on.
   task automatic test_reset_mid();
      logic [9:0] bits;
      bit         stable;
      int         eot_low;
      kick(8'h00);
      repeat (4 * BIT + 400) @(negedge Clk);
      checks++;
      if (TX !== 1'b0 || EOT !== 1'b0) $display("FAIL pre_abort: TX=%b EOT=%b required 0 0", TX, EOT);
      else passed++;
      #2 Rst_n = 1'b0;
      #1;
      checks++;
      if (TX !== 1'b1 || EOT !== 1'b1) $display("FAIL async_abort: TX=%b EOT=%b required 1 1", TX, EOT);
      else passed++;
      @(negedge Clk);
      @(negedge Clk);
      Rst_n = 1'b1;
      Data  = 8'hCC;
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      Data  = 8'h33;
      capture_frame(-1, bits, stable, eot_low);
      checks++;
      if (bits !== 10'b1110011000 || stable !== 1'b1 || eot_low !== FRAME)
         $display("FAIL post_reset_cc: got %b stable=%b low=%0d required %b 1 %0d",
                  bits, stable, eot_low, 10'b1110011000, FRAME);
      else passed++;
      $display("abort in bit 3 then 0xCC: bits=%b eot_low=%0d", bits, eot_low);
   endtask

   task automatic test_back_to_back();
      int low_cnt;
      checks++;
      if (EOT !== 1'b1) $display("FAIL b2b_eot_rise: EOT=%b required 1", EOT);
      else passed++;
      Data  = 8'h0F;
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      Data  = 8'h00;
      checks++;
      if (TX !== 1'b0 || EOT !== 1'b0) $display("FAIL b2b_start: TX=%b EOT=%b required 0 0", TX, EOT);
      else passed++;
      low_cnt = 0;
      while (TX === 1'b0 && low_cnt < 2000) begin
         low_cnt++;
         @(negedge Clk);
      end
      checks++;
      if (low_cnt !== BIT) $display("FAIL b2b_start_len: got %0d required %0d", low_cnt, BIT);
      else passed++;
      $display("back-to-back 0x0F: start bit %0d cycles", low_cnt);
      Rst_n = 1'b0;
      @(negedge Clk);
      Rst_n = 1'b1;
   endtask

   task automatic test_speed();
      int low_cnt;
      @(negedge Clk);
      Data2  = 8'hFF;
      Start2 = 1'b1;
      @(negedge Clk);
      Start2 = 1'b0;
      checks++;
      if (EOT2 !== 1'b0) $display("FAIL slow_eot: EOT=%b required 0", EOT2);
      else passed++;
      low_cnt = 0;
      while (TX2 === 1'b0 && low_cnt < 12000) begin
         low_cnt++;
         @(negedge Clk);
      end
      checks++;
      if (low_cnt !== SLOW_BIT) $display("FAIL slow_bit_len: got %0d required %0d", low_cnt, SLOW_BIT);
      else passed++;
      $display("9600 baud: start bit %0d cycles", low_cnt);
   endtask

   initial begin
      test_reset();
      test_single();
      test_two_frames();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      test_speed();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
